// File: rtl/d_bus_arb.sv
// d_bus_arb: two-master round-robin arbiter for the data-side bus.
// Master 0 is the core load/store unit. Master 1 is the debug/loader port.
// A read that is not answered in its grant cycle locks the bus to its owner
// until the read completes or the watchdog expires.
//
// Handshake: a master holds rd_req/wr_req (with addr/be/data) stable until it
// sees the matching ready pulse. A write is accepted in any cycle where the
// granted master's s_wr_req and s_wr_ready are both high. A read completes in
// any cycle where s_rd_req and s_rd_ready are both high. The master samples
// rd_data only in the cycle its rd_ready is high.
module d_bus_arb #(
  parameter int XLEN      = 32,
  parameter int ADDR_LEN  = 14,
  parameter int TO_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rstb,
  // master 0
  input  logic [ADDR_LEN-1:0] m0_addr,
  input  logic                m0_rd_req,
  input  logic                m0_wr_req,
  input  logic [XLEN/8-1:0]   m0_wr_be,
  input  logic [XLEN-1:0]     m0_wr_data,
  output logic [XLEN-1:0]     m0_rd_data,
  output logic                m0_rd_ready,
  output logic                m0_wr_ready,
  // master 1
  input  logic [ADDR_LEN-1:0] m1_addr,
  input  logic                m1_rd_req,
  input  logic                m1_wr_req,
  input  logic [XLEN/8-1:0]   m1_wr_be,
  input  logic [XLEN-1:0]     m1_wr_data,
  output logic [XLEN-1:0]     m1_rd_data,
  output logic                m1_rd_ready,
  output logic                m1_wr_ready,
  // shared slave side
  output logic [ADDR_LEN-1:0] s_addr,
  output logic                s_rd_req,
  output logic                s_wr_req,
  output logic [XLEN/8-1:0]   s_wr_be,
  output logic [XLEN-1:0]     s_wr_data,
  input  logic [XLEN-1:0]     s_rd_data,
  input  logic                s_rd_ready,
  input  logic                s_wr_ready,
  // watchdog error report
  output logic                bus_err,
  output logic                bus_err_src,
  // debug: current FSM state (0 = IDLE, 1 = RD_WAIT)
  output logic                dbg_state
);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TO_CYCLES);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_gnt_q, last_gnt_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       bus_err_q, bus_err_d;
  logic       bus_err_src_q, bus_err_src_d;

  logic req0, req1, any_req, gnt, sel;
  logic                sel_rd, sel_wr;
  logic [ADDR_LEN-1:0] sel_addr;
  logic [XLEN/8-1:0]   sel_be;
  logic [XLEN-1:0]     sel_wdata;
  logic                rd_done, wr_done;
  logic [XLEN-1:0]     rd_data_v;

  // Arbitration: a lone requester wins; on a tie the master not served last wins.
  assign req0    = m0_rd_req | m0_wr_req;
  assign req1    = m1_rd_req | m1_wr_req;
  assign any_req = req0 | req1;
  assign gnt     = (req0 & req1) ? ~last_gnt_q : req1;
  // While a read is outstanding the locked owner selects the bus, not the arbiter.
  assign sel     = (state_q == RD_WAIT) ? owner_q : gnt;

  assign sel_rd    = sel ? m1_rd_req  : m0_rd_req;
  assign sel_wr    = sel ? m1_wr_req  : m0_wr_req;
  assign sel_addr  = sel ? m1_addr    : m0_addr;
  assign sel_be    = sel ? m1_wr_be   : m0_wr_be;
  assign sel_wdata = sel ? m1_wr_data : m0_wr_data;

  // State and bookkeeping registers; reset abandons any in-flight read.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_gnt_q    <= 1'b1;
      to_cnt_q      <= 8'd0;
      bus_err_q     <= 1'b0;
      bus_err_src_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_gnt_q    <= last_gnt_d;
      to_cnt_q      <= to_cnt_d;
      bus_err_q     <= bus_err_d;
      bus_err_src_q <= bus_err_src_d;
    end
  end

  // Next state and slave-side outputs. Everything is forced idle while rstb is low.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_gnt_d    = last_gnt_q;
    to_cnt_d      = to_cnt_q;
    bus_err_d     = 1'b0;
    bus_err_src_d = bus_err_src_q;
    s_addr        = '0;
    s_rd_req      = 1'b0;
    s_wr_req      = 1'b0;
    s_wr_be       = '0;
    s_wr_data     = '0;
    rd_done       = 1'b0;
    wr_done       = 1'b0;
    rd_data_v     = '0;
    if (rstb) begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            s_addr    = sel_addr;
            s_wr_be   = sel_be;
            s_wr_data = sel_wdata;
            if (sel_wr) begin
              // Write takes precedence; a read held alongside it waits its turn.
              s_wr_req = 1'b1;
              wr_done  = s_wr_ready;
              if (s_wr_ready) last_gnt_d = gnt;
            end else if (sel_rd) begin
              s_rd_req   = 1'b1;
              last_gnt_d = gnt;
              if (s_rd_ready) begin
                rd_done   = 1'b1;
                rd_data_v = s_rd_data;
              end else begin
                owner_d  = gnt;
                to_cnt_d = 8'd1;
                state_d  = RD_WAIT;
              end
            end
          end
        end
        RD_WAIT: begin
          // Read stays asserted even if the owner has withdrawn its request.
          s_addr    = sel_addr;
          s_wr_be   = sel_be;
          s_wr_data = sel_wdata;
          s_rd_req  = 1'b1;
          to_cnt_d  = to_cnt_q + 8'd1;
          if (s_rd_ready) begin
            rd_done   = 1'b1;
            rd_data_v = s_rd_data;
            state_d   = IDLE;
          end else if (to_cnt_q == TO_LIM) begin
            rd_done       = 1'b1;
            bus_err_d     = 1'b1;
            bus_err_src_d = owner_q;
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Completion routing to the selected master only; read data is zero outside rd_ready.
  assign m0_rd_ready = rd_done & ~sel;
  assign m1_rd_ready = rd_done &  sel;
  assign m0_wr_ready = wr_done & ~sel;
  assign m1_wr_ready = wr_done &  sel;
  assign m0_rd_data  = m0_rd_ready ? rd_data_v : '0;
  assign m1_rd_data  = m1_rd_ready ? rd_data_v : '0;

  assign bus_err     = bus_err_q;
  assign bus_err_src = bus_err_src_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_d_bus_arb.sv
// tb_d_bus_arb: directed test of d_bus_arb with hand-computed expectations.
module tb_d_bus_arb;

  localparam int XLEN = 32;
  localparam int AL   = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  logic [AL-1:0]     m0_addr, m1_addr, s_addr;
  logic              m0_rd_req, m0_wr_req, m1_rd_req, m1_wr_req;
  logic [XLEN/8-1:0] m0_wr_be, m1_wr_be, s_wr_be;
  logic [XLEN-1:0]   m0_wr_data, m1_wr_data, s_wr_data;
  logic [XLEN-1:0]   m0_rd_data, m1_rd_data, s_rd_data;
  logic              m0_rd_ready, m0_wr_ready, m1_rd_ready, m1_wr_ready;
  logic              s_rd_req, s_wr_req, s_rd_ready, s_wr_ready;
  logic              bus_err, bus_err_src, dbg_state;

  d_bus_arb #(.XLEN(XLEN), .ADDR_LEN(AL), .TO_CYCLES(8)) dut (
    .clk(clk), .rstb(rstb),
    .m0_addr(m0_addr), .m0_rd_req(m0_rd_req), .m0_wr_req(m0_wr_req),
    .m0_wr_be(m0_wr_be), .m0_wr_data(m0_wr_data), .m0_rd_data(m0_rd_data),
    .m0_rd_ready(m0_rd_ready), .m0_wr_ready(m0_wr_ready),
    .m1_addr(m1_addr), .m1_rd_req(m1_rd_req), .m1_wr_req(m1_wr_req),
    .m1_wr_be(m1_wr_be), .m1_wr_data(m1_wr_data), .m1_rd_data(m1_rd_data),
    .m1_rd_ready(m1_rd_ready), .m1_wr_ready(m1_wr_ready),
    .s_addr(s_addr), .s_rd_req(s_rd_req), .s_wr_req(s_wr_req),
    .s_wr_be(s_wr_be), .s_wr_data(s_wr_data), .s_rd_data(s_rd_data),
    .s_rd_ready(s_rd_ready), .s_wr_ready(s_wr_ready),
    .bus_err(bus_err), .bus_err_src(bus_err_src), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: expected queue empty, got 0x%0h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    m0_addr = '0; m0_rd_req = 0; m0_wr_req = 0; m0_wr_be = '0; m0_wr_data = '0;
    m1_addr = '0; m1_rd_req = 0; m1_wr_req = 0; m1_wr_be = '0; m1_wr_data = '0;
    s_rd_data = '0; s_rd_ready = 0; s_wr_ready = 0;
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 time units later.
  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    to_neg();
    rstb = 1'b0;
    clear_inputs();
    repeat (2) to_neg();
    rstb = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstb = 1'b0;
    clear_inputs();
    settle();
    chk("rst_s_rd_req", s_rd_req, 0);
    chk("rst_s_wr_req", s_wr_req, 0);
    chk("rst_m0_rd_ready", m0_rd_ready, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_bus_err_src", bus_err_src, 0);
    chk("rst_state", dbg_state, 0);
    repeat (2) to_neg();
    rstb = 1'b1;

    // --- m0 write, accepted in the grant cycle ---
    to_neg();
    m0_addr = 14'h100; m0_wr_data = 32'hA5A5A5A5; m0_wr_be = 4'hF; m0_wr_req = 1;
    s_wr_ready = 1;
    settle();
    chk("wr_s_wr_req", s_wr_req, 1);
    chk("wr_s_addr", s_addr, 32'h100);
    chk("wr_s_wr_data", s_wr_data, 32'hA5A5A5A5);
    chk("wr_s_wr_be", s_wr_be, 4'hF);
    chk("wr_s_rd_req", s_rd_req, 0);
    chk("wr_m0_wr_ready", m0_wr_ready, 1);
    chk("wr_m1_wr_ready", m1_wr_ready, 0);
    chk("wr_m1_rd_ready", m1_rd_ready, 0);
    to_neg();
    clear_inputs();
    settle();
    chk("wr_idle_s_wr_req", s_wr_req, 0);

    // --- m0 read 0x104, answered one cycle later ---
    to_neg();
    m0_addr = 14'h104; m0_rd_req = 1;
    settle();
    chk("rd_s_rd_req", s_rd_req, 1);
    chk("rd_s_addr", s_addr, 32'h104);
    chk("rd_m0_rd_ready_early", m0_rd_ready, 0);
    to_neg();
    s_rd_ready = 1; s_rd_data = 32'h12345678;
    exp_q.push_back(32'h12345678);
    settle();
    chk("rd_state_wait", dbg_state, 1);
    chk("rd_m0_rd_ready", m0_rd_ready, 1);
    chk_rd("rd_m0_rd_data", m0_rd_data);
    chk("rd_m1_rd_data", m1_rd_data, 0);
    to_neg();
    clear_inputs();
    settle();
    chk("rd_done_ready", m0_rd_ready, 0);
    chk("rd_done_data", m0_rd_data, 0);
    chk("rd_done_state", dbg_state, 0);

    // --- simultaneous reads from reset: m0 first, m1 next ---
    do_reset();
    m0_addr = 14'h010; m1_addr = 14'h020; m0_rd_req = 1; m1_rd_req = 1;
    settle();
    chk("tie1_s_addr", s_addr, 32'h010);
    to_neg();
    settle();
    chk("tie1_hold_addr", s_addr, 32'h010);
    chk("tie1_m1_stalled", m1_rd_ready, 0);
    s_rd_ready = 1; s_rd_data = 32'h111;
    exp_q.push_back(32'h111);
    settle();
    chk("tie1_m0_rd_ready", m0_rd_ready, 1);
    chk_rd("tie1_m0_rd_data", m0_rd_data);
    chk("tie1_m1_rd_ready", m1_rd_ready, 0);
    // m0 keeps requesting back-to-back; m1's pending request must win.
    to_neg();
    s_rd_ready = 0; s_rd_data = '0;
    settle();
    chk("tie1_reissue_addr", s_addr, 32'h020);
    chk("tie1_reissue_rd", s_rd_req, 1);
    to_neg();
    s_rd_ready = 1; s_rd_data = 32'h222;
    exp_q.push_back(32'h222);
    settle();
    chk("tie1_m1_rd_ready", m1_rd_ready, 1);
    chk_rd("tie1_m1_rd_data", m1_rd_data);
    chk("tie1_m0_not_ready", m0_rd_ready, 0);
    // m0 alone now, answered in its grant cycle.
    to_neg();
    m1_rd_req = 0; s_rd_ready = 1; s_rd_data = 32'h333;
    exp_q.push_back(32'h333);
    settle();
    chk("same_cyc_addr", s_addr, 32'h010);
    chk("same_cyc_m0_ready", m0_rd_ready, 1);
    chk_rd("same_cyc_m0_data", m0_rd_data);
    // Tie again with m0 served last: m1 must go first.
    to_neg();
    m1_rd_req = 1; s_rd_ready = 1; s_rd_data = 32'h444;
    exp_q.push_back(32'h444);
    settle();
    chk("tie2_s_addr", s_addr, 32'h020);
    chk("tie2_m1_ready", m1_rd_ready, 1);
    chk_rd("tie2_m1_data", m1_rd_data);
    chk("tie2_m0_ready", m0_rd_ready, 0);
    to_neg();
    clear_inputs();

    // --- m1 read never answered: watchdog after 8 wait cycles ---
    do_reset();
    m1_addr = 14'h030; m1_rd_req = 1; s_rd_data = 32'hDEADBEEF;
    for (int k = 1; k <= 8; k++) begin
      to_neg();
      settle();
      if (k < 8) chk($sformatf("to_wait%0d_ready", k), m1_rd_ready, 0);
      chk($sformatf("to_wait%0d_err", k), bus_err, 0);
    end
    chk("to_m1_rd_ready", m1_rd_ready, 1);
    chk("to_m1_rd_data", m1_rd_data, 0);
    chk("to_m0_rd_ready", m0_rd_ready, 0);
    to_neg();
    m1_rd_req = 0; s_rd_ready = 1;
    settle();
    chk("to_bus_err", bus_err, 1);
    chk("to_bus_err_src", bus_err_src, 1);
    chk("to_late_m1_ready", m1_rd_ready, 0);
    chk("to_late_m1_data", m1_rd_data, 0);
    chk("to_late_s_rd_req", s_rd_req, 0);
    chk("to_state_idle", dbg_state, 0);
    to_neg();
    s_rd_ready = 0;
    settle();
    chk("to_err_pulse_end", bus_err, 0);
    chk("to_err_src_hold", bus_err_src, 1);

    // --- m0 read+write together: write first ---
    to_neg();
    clear_inputs();
    m0_addr = 14'h040; m0_rd_req = 1; m0_wr_req = 1; m0_wr_data = 32'hCAFE0001;
    m0_wr_be = 4'h3; s_wr_ready = 1;
    settle();
    chk("rw_s_wr_req", s_wr_req, 1);
    chk("rw_s_rd_req", s_rd_req, 0);
    chk("rw_m0_wr_ready", m0_wr_ready, 1);
    chk("rw_m0_rd_ready", m0_rd_ready, 0);
    to_neg();
    m0_wr_req = 0; s_wr_ready = 0;
    settle();
    chk("rw_rd_issue", s_rd_req, 1);
    chk("rw_wr_gone", s_wr_req, 0);
    to_neg();
    s_rd_ready = 1; s_rd_data = 32'h55;
    exp_q.push_back(32'h55);
    settle();
    chk("rw_m0_rd_ready2", m0_rd_ready, 1);
    chk_rd("rw_m0_rd_data", m0_rd_data);
    to_neg();
    clear_inputs();

    // --- reset during RD_WAIT, then a clean read ---
    to_neg();
    m0_addr = 14'h050; m0_rd_req = 1;
    to_neg();
    settle();
    chk("rst_mid_state", dbg_state, 1);
    rstb = 0;
    settle();
    chk("rst_mid_s_rd_req", s_rd_req, 0);
    chk("rst_mid_s_addr", s_addr, 0);
    chk("rst_mid_m0_ready", m0_rd_ready, 0);
    chk("rst_mid_state_idle", dbg_state, 0);
    to_neg();
    rstb = 1;
    settle();
    chk("post_rst_s_rd_req", s_rd_req, 1);
    chk("post_rst_s_addr", s_addr, 32'h050);
    to_neg();
    s_rd_ready = 1; s_rd_data = 32'h66;
    exp_q.push_back(32'h66);
    settle();
    chk("post_rst_m0_ready", m0_rd_ready, 1);
    chk_rd("post_rst_m0_data", m0_rd_data);
    to_neg();
    clear_inputs();

    // ---------------- final report ----------------
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL exp_q_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
